// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, synchronous-read memory (read data on Q one
// cycle after the address) between the instruction-fetch unit and the data
// load/store unit. At most one access is issued per cycle. Data accesses win
// contention by default. A starvation counter forces a fetch grant after
// STARVE_MAX consecutive denied fetch cycles.
//
// Read responses come back with a registered valid to the port that issued
// them. Between responses each port's rdata holds the last word it received.
//
// Parameters
//   ADDR        word-address width
//   WORD        data width
//   STARVE_MAX  denied fetch cycles tolerated before fetch is forced to win;
//               0 means fetch always wins ties
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-low reset
//   if_req_i      fetch read request (held with if_addr_i until granted)
//   if_addr_i     fetch address
//   if_gnt_o      fetch request accepted this cycle
//   if_stall_o    fetch requesting but not granted
//   if_rvalid_o   fetch read data valid
//   if_rdata_o    fetch read data
//   d_req_i       data request (held with its fields until granted)
//   d_we_i        1 = write, 0 = read
//   d_addr_i      data address
//   d_wdata_i     data write data
//   d_gnt_o       data request accepted this cycle
//   d_rvalid_o    data read data valid (reads only)
//   d_rdata_o     data read data
//   mem_a_o       memory address
//   mem_w_o       memory write enable
//   mem_d_o       memory write data
//   mem_q_i       memory read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR       = 16,
  parameter int WORD       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req_i,
  input  logic [ADDR-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_stall_o,
  output logic            if_rvalid_o,
  output logic [WORD-1:0] if_rdata_o,

  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [ADDR-1:0] d_addr_i,
  input  logic [WORD-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [WORD-1:0] d_rdata_o,

  output logic [ADDR-1:0] mem_a_o,
  output logic            mem_w_o,
  output logic [WORD-1:0] mem_d_o,
  input  logic [WORD-1:0] mem_q_i
);

  // With STARVE_MAX = 0 the counter never leaves zero, but it still needs
  // at least one bit to be a legal vector.
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            if_rvalid_q,  if_rvalid_d;
  logic            d_rvalid_q,   d_rvalid_d;
  logic [WORD-1:0] if_hold_q,    if_hold_d;
  logic [WORD-1:0] d_hold_q,     d_hold_d;

  logic            fetch_forced;
  logic            if_gnt;
  logic            d_gnt;

  // Grant decision. Nothing is granted while reset is held, so no write can
  // reach the memory during reset. When both ports request, fetch only wins
  // once it has been denied STARVE_MAX cycles in a row.
  always_comb begin
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    fetch_forced = (starve_cnt_q == CNT_MAX);
    if (rst) begin
      if (if_req_i && d_req_i) begin
        if (fetch_forced) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else if (if_req_i) begin
        if_gnt = 1'b1;
      end else if (d_req_i) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory drive. Write data is passed straight through; it only matters
  // when the data port holds the grant with a write.
  always_comb begin
    mem_a_o = if_addr_i;
    mem_w_o = 1'b0;
    mem_d_o = d_wdata_i;
    if (d_gnt) begin
      mem_a_o = d_addr_i;
      mem_w_o = d_we_i;
    end
  end

  // Starvation counter: counts consecutive cycles in which fetch asked and
  // was refused. Any fetch grant, or fetch withdrawing its request, clears it.
  always_comb begin
    starve_cnt_d = '0;
    if (if_req_i && !if_gnt) begin
      if (starve_cnt_q == CNT_MAX) begin
        starve_cnt_d = CNT_MAX;
      end else begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Response pipeline. The memory presents Q one cycle after the address, so
  // the valid is just the grant delayed by one cycle. Data writes have no
  // response. The hold registers remember the last delivered word so the
  // rdata outputs stay stable between responses.
  always_comb begin
    if_rvalid_d = if_gnt;
    d_rvalid_d  = d_gnt && !d_we_i;
    if_hold_d   = if_rvalid_q ? mem_q_i : if_hold_q;
    d_hold_d    = d_rvalid_q  ? mem_q_i : d_hold_q;
  end

  // State registers. Reset drops any response still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_hold_q    <= '0;
      d_hold_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_hold_q    <= if_hold_d;
      d_hold_q     <= d_hold_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign d_gnt_o     = d_gnt;
  assign if_stall_o  = if_req_i && !if_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;

  // While a response is being delivered the memory output is forwarded
  // directly; otherwise the port sees its held word.
  assign if_rdata_o  = if_rvalid_q ? mem_q_i : if_hold_q;
  assign d_rdata_o   = d_rvalid_q  ? mem_q_i : d_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with STARVE_MAX = 4. Each stimulus
// step drives both requesters, checks grants and memory drive against the
// hand-computed expectation, and queues the read word each granted read must
// return one cycle later. A separate monitor pops those expectations when a
// port raises rvalid. A small synchronous-read memory model sits on the
// memory port.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR = 16;
  localparam int WORD = 32;

  logic            clk;
  logic            rst;
  logic            if_req_i;
  logic [ADDR-1:0] if_addr_i;
  logic            if_gnt_o;
  logic            if_stall_o;
  logic            if_rvalid_o;
  logic [WORD-1:0] if_rdata_o;
  logic            d_req_i;
  logic            d_we_i;
  logic [ADDR-1:0] d_addr_i;
  logic [WORD-1:0] d_wdata_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [WORD-1:0] d_rdata_o;
  logic [ADDR-1:0] mem_a_o;
  logic            mem_w_o;
  logic [WORD-1:0] mem_d_o;
  logic [WORD-1:0] mem_q_i;

  mem_port_arbiter #(.ADDR(ADDR), .WORD(WORD), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_stall_o (if_stall_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .mem_a_o    (mem_a_o),
    .mem_w_o    (mem_w_o),
    .mem_d_o    (mem_d_o),
    .mem_q_i    (mem_q_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: Q shows the addressed word one cycle later,
  // writes land at the end of the cycle they are presented.
  logic [WORD-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_w_o) mem[mem_a_o] <= mem_d_o;
    mem_q_i <= mem[mem_a_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [WORD-1:0] word;
  } exp_t;

  exp_t if_exp[$];
  exp_t d_exp[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  function automatic void check(string name, logic [WORD-1:0] act, logic [WORD-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every rvalid must match the oldest queued expectation due this
  // cycle; an expectation whose cycle has passed was never delivered.
  always @(negedge clk) begin
    if (mon_en) begin
      while (if_exp.size() > 0 && if_exp[0].due < cyc) begin
        check("if_rvalid_missing", 32'd0, 32'd1);
        void'(if_exp.pop_front());
      end
      while (d_exp.size() > 0 && d_exp[0].due < cyc) begin
        check("d_rvalid_missing", 32'd0, 32'd1);
        void'(d_exp.pop_front());
      end
      if (if_rvalid_o) begin
        if (if_exp.size() > 0 && if_exp[0].due == cyc) begin
          check("if_rdata", if_rdata_o, if_exp[0].word);
          void'(if_exp.pop_front());
        end else begin
          check("if_rvalid_unexpected", 32'd1, 32'd0);
        end
      end
      if (d_rvalid_o) begin
        if (d_exp.size() > 0 && d_exp[0].due == cyc) begin
          check("d_rdata", d_rdata_o, d_exp[0].word);
          void'(d_exp.pop_front());
        end else begin
          check("d_rvalid_unexpected", 32'd1, 32'd0);
        end
      end
    end
  end

  // Compares grants, stall and memory drive for the current cycle; when asked,
  // also compares the rdata outputs against the words they should be holding.
  task automatic checkOutput(string name, bit e_ifg, bit e_dg, bit e_stall, bit e_w,
                             logic [ADDR-1:0] e_a, bit chk_hold,
                             logic [WORD-1:0] e_if_hold, logic [WORD-1:0] e_d_hold);
    check({name, ".if_gnt"},   {31'd0, if_gnt_o},   {31'd0, e_ifg});
    check({name, ".d_gnt"},    {31'd0, d_gnt_o},    {31'd0, e_dg});
    check({name, ".if_stall"}, {31'd0, if_stall_o}, {31'd0, e_stall});
    check({name, ".mem_w"},    {31'd0, mem_w_o},    {31'd0, e_w});
    check({name, ".mem_a"},    {16'd0, mem_a_o},    {16'd0, e_a});
    if (chk_hold) begin
      check({name, ".if_rdata_hold"}, if_rdata_o, e_if_hold);
      check({name, ".d_rdata_hold"},  d_rdata_o,  e_d_hold);
    end
  endtask

  // One cycle of stimulus. Inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge. A granted read queues the word
  // the owning port must see on the following cycle.
  task automatic applyStimulus(string name, bit r,
                               bit ifr, logic [ADDR-1:0] ifa,
                               bit dr, bit dwe, logic [ADDR-1:0] da, logic [WORD-1:0] dwd,
                               bit e_ifg, bit e_dg, logic [WORD-1:0] e_word,
                               bit chk_hold = 1'b0,
                               logic [WORD-1:0] e_if_hold = '0,
                               logic [WORD-1:0] e_d_hold = '0);
    exp_t e;
    rst       = r;
    if_req_i  = ifr;
    if_addr_i = ifa;
    d_req_i   = dr;
    d_we_i    = dwe;
    d_addr_i  = da;
    d_wdata_i = dwd;
    @(negedge clk);
    checkOutput(name, e_ifg, e_dg, ifr && !e_ifg, e_dg && dwe,
                e_dg ? da : ifa, chk_hold, e_if_hold, e_d_hold);
    e.due  = cyc + 1;
    e.word = e_word;
    if (e_ifg) if_exp.push_back(e);
    if (e_dg && !dwe) d_exp.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(string name, int n);
    for (int i = 0; i < n; i++)
      applyStimulus(name, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Both ports requesting: fetch reads 0x0020, data reads 0x0030.
  task automatic bothReq(string name, bit e_ifg);
    applyStimulus(name, 1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0030, 32'h0,
                  e_ifg, !e_ifg, e_ifg ? 32'h0000AA20 : 32'h0000BB30);
  endtask

  initial begin
    for (int a = 0; a < 4; a++) mem[a] = 32'h100 + a;
    mem[16'h0020] = 32'h0000AA20;
    mem[16'h0021] = 32'h0000AA21;
    mem[16'h0030] = 32'h0000BB30;
    mem[16'h0040] = 32'h0;
    mem[16'h0080] = 32'h12345678;

    // Reset held with both ports requesting: nothing granted, no write.
    applyStimulus("reset1", 1'b0, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0030, 32'hFFFF0000,
                  1'b0, 1'b0, 32'h0);
    mon_en = 1'b1;
    applyStimulus("reset2", 1'b0, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0030, 32'hFFFF0000,
                  1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);

    // Continuous contention: data wins first after reset, then 4:1 pattern.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) bothReq("contend_d", 1'b0);
      bothReq("contend_if", 1'b1);
    end
    idle("idle_a", 1);

    // Fetch only, consecutive addresses.
    for (int a = 0; a < 4; a++)
      applyStimulus("fetch_only", 1'b1, 1'b1, 16'(a), 1'b0, 1'b0, 16'h0, 32'h0,
                    1'b1, 1'b0, 32'h100 + a);
    idle("idle_b", 1);

    // Data write then read-back of the same address.
    applyStimulus("d_write", 1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 32'hDEADBEEF,
                  1'b0, 1'b1, 32'h0);
    applyStimulus("d_read", 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 32'h0,
                  1'b0, 1'b1, 32'hDEADBEEF);
    idle("idle_c", 1);
    applyStimulus("d_hold", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0,
                  1'b0, 1'b0, 32'h0, 1'b1, 32'h00000103, 32'hDEADBEEF);

    // Fetch read, then the word must hold through three quiet cycles.
    applyStimulus("if_read", 1'b1, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0, 32'h0,
                  1'b1, 1'b0, 32'h12345678);
    for (int i = 0; i < 3; i++)
      applyStimulus("if_hold", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0,
                    1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, 32'hDEADBEEF);

    // Cancel: fetch denied twice, then withdraws. The counter must restart,
    // so the next contention again gives data four grants before fetch.
    applyStimulus("cancel_d1", 1'b1, 1'b1, 16'h0021, 1'b1, 1'b0, 16'h0030, 32'h0,
                  1'b0, 1'b1, 32'h0000BB30);
    applyStimulus("cancel_d2", 1'b1, 1'b1, 16'h0021, 1'b1, 1'b0, 16'h0030, 32'h0,
                  1'b0, 1'b1, 32'h0000BB30);
    applyStimulus("cancel_drop", 1'b1, 1'b0, 16'h0021, 1'b1, 1'b0, 16'h0030, 32'h0,
                  1'b0, 1'b1, 32'h0000BB30);
    for (int i = 0; i < 4; i++)
      applyStimulus("cancel_then_d", 1'b1, 1'b1, 16'h0021, 1'b1, 1'b0, 16'h0030, 32'h0,
                    1'b0, 1'b1, 32'h0000BB30);
    applyStimulus("cancel_then_if", 1'b1, 1'b1, 16'h0021, 1'b1, 1'b0, 16'h0030, 32'h0,
                  1'b1, 1'b0, 32'h0000AA21);
    idle("idle_d", 1);

    // Reset mid-operation: counter built up to 4 by the last pre-reset grant.
    for (int i = 0; i < 4; i++) bothReq("pre_rst_d", 1'b0);
    applyStimulus("mid_reset", 1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0030, 32'h0,
                  1'b0, 1'b0, 32'h0);
    applyStimulus("post_rst_d", 1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0030, 32'h0,
                  1'b0, 1'b1, 32'h0000BB30, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) bothReq("post_rst_d", 1'b0);
    bothReq("post_rst_if", 1'b1);
    idle("idle_e", 2);

    check("if_exp_drained", 32'(if_exp.size()), 32'd0);
    check("d_exp_drained",  32'(d_exp.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
